pipe_wb_stage: RTL and testbench

Write-back stage of the dynamic pipeline CPU: the consumer at the far end of the memory stage's outputs. It latches the memory-stage bundle into a MEM/WB register, extracts and extends load data, selects the register-file write value, and owns the architectural HI/LO registers. It drives the register-file write port and the HI/LO bypass values back toward decode/execute.

---
 rtl/pipe_wb_if.sv | 28 ++
 rtl/pipe_wb_stage.sv | 121 ++++++++++++
 tb/tb_pipe_wb_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_wb_if.sv
// Memory-stage to write-back bundle plus the write-back results returned to decode/execute.
interface pipe_wb_if;
  logic        stall;
  logic        flush;
  logic [31:0] Malu, Ma, Mdm, Mpc4, Mcp0, Mcounter, Mq, Mr, Mmuler_hi, Mmuler_lo;
  logic [2:0]  Mrfsource;
  logic [1:0]  Mcuttersource;
  logic        Msign;
  logic [1:0]  Mhisource, Mlosource;
  logic [4:0]  Mrn;
  logic        Mw_rf, Mw_hi, Mw_lo;
  logic        wb_we;
  logic [4:0]  wb_rn;
  logic [31:0] wb_data;
  logic [31:0] hi, lo, hi_next, lo_next;

  modport master (
    output stall, flush, Malu, Ma, Mdm, Mpc4, Mcp0, Mcounter, Mq, Mr, Mmuler_hi, Mmuler_lo,
           Mrfsource, Mcuttersource, Msign, Mhisource, Mlosource, Mrn, Mw_rf, Mw_hi, Mw_lo,
    input  wb_we, wb_rn, wb_data, hi, lo, hi_next, lo_next
  );

  modport slave (
    input  stall, flush, Malu, Ma, Mdm, Mpc4, Mcp0, Mcounter, Mq, Mr, Mmuler_hi, Mmuler_lo,
           Mrfsource, Mcuttersource, Msign, Mhisource, Mlosource, Mrn, Mw_rf, Mw_hi, Mw_lo,
    output wb_we, wb_rn, wb_data, hi, lo, hi_next, lo_next
  );
endinterface

// File: rtl/pipe_wb_stage.sv
// Write-back stage: MEM/WB register, load cutter, rf write-data select and architectural HI/LO.
module pipe_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  pipe_wb_if.slave    wb
);
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic [DW-1:0] w_alu, w_a, w_dm, w_pc4, w_cp0, w_counter, w_q, w_r, w_muler_hi, w_muler_lo;
  logic [2:0]    w_rfsource;
  logic [1:0]    w_cuttersource;
  logic          w_sign;
  logic [1:0]    w_hisource, w_losource;
  logic [RW-1:0] w_rn;
  logic          w_w_rf, w_w_hi, w_w_lo;

  logic [DW-1:0] hi_q, lo_q;
  logic [DW-1:0] hi_next_c, lo_next_c;
  logic [DW-1:0] cut_c;
  logic [DW-1:0] wb_data_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;

  // MEM/WB register: flush loads a bubble ahead of stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_alu <= '0; w_a <= '0; w_dm <= '0; w_pc4 <= '0; w_cp0 <= '0;
      w_counter <= '0; w_q <= '0; w_r <= '0; w_muler_hi <= '0; w_muler_lo <= '0;
      w_rfsource <= '0; w_cuttersource <= '0; w_sign <= 1'b0;
      w_hisource <= '0; w_losource <= '0; w_rn <= '0;
      w_w_rf <= 1'b0; w_w_hi <= 1'b0; w_w_lo <= 1'b0;
    end else if (wb.flush) begin
      w_alu <= '0; w_a <= '0; w_dm <= '0; w_pc4 <= '0; w_cp0 <= '0;
      w_counter <= '0; w_q <= '0; w_r <= '0; w_muler_hi <= '0; w_muler_lo <= '0;
      w_rfsource <= '0; w_cuttersource <= '0; w_sign <= 1'b0;
      w_hisource <= '0; w_losource <= '0; w_rn <= '0;
      w_w_rf <= 1'b0; w_w_hi <= 1'b0; w_w_lo <= 1'b0;
    end else if (!wb.stall) begin
      w_alu <= wb.Malu; w_a <= wb.Ma; w_dm <= wb.Mdm; w_pc4 <= wb.Mpc4; w_cp0 <= wb.Mcp0;
      w_counter <= wb.Mcounter; w_q <= wb.Mq; w_r <= wb.Mr;
      w_muler_hi <= wb.Mmuler_hi; w_muler_lo <= wb.Mmuler_lo;
      w_rfsource <= wb.Mrfsource; w_cuttersource <= wb.Mcuttersource; w_sign <= wb.Msign;
      w_hisource <= wb.Mhisource; w_losource <= wb.Mlosource; w_rn <= wb.Mrn;
      w_w_rf <= wb.Mw_rf; w_w_hi <= wb.Mw_hi; w_w_lo <= wb.Mw_lo;
    end
  end

  // Load cutter: lane extraction then sign or zero extension
  always_comb begin
    byte_c = w_dm[7:0];
    half_c = w_alu[1] ? w_dm[31:16] : w_dm[15:0];
    cut_c  = w_dm;
    case (w_alu[1:0])
      2'd0:    byte_c = w_dm[7:0];
      2'd1:    byte_c = w_dm[15:8];
      2'd2:    byte_c = w_dm[23:16];
      default: byte_c = w_dm[31:24];
    endcase
    case (w_cuttersource)
      2'd1:    cut_c = {{24{w_sign & byte_c[7]}}, byte_c};
      2'd2:    cut_c = {{16{w_sign & half_c[15]}}, half_c};
      default: cut_c = w_dm;
    endcase
  end

  // Register-file write data; HI/LO sources read the architectural value
  always_comb begin
    wb_data_c = w_alu;
    case (w_rfsource)
      3'd0:    wb_data_c = w_alu;
      3'd1:    wb_data_c = cut_c;
      3'd2:    wb_data_c = w_pc4;
      3'd3:    wb_data_c = hi_q;
      3'd4:    wb_data_c = lo_q;
      3'd5:    wb_data_c = w_cp0;
      3'd6:    wb_data_c = w_counter;
      default: wb_data_c = w_muler_lo;
    endcase
  end

  always_comb begin
    hi_next_c = hi_q;
    lo_next_c = lo_q;
    if (w_w_hi) begin
      case (w_hisource)
        2'd0:    hi_next_c = w_a;
        2'd1:    hi_next_c = w_muler_hi;
        2'd2:    hi_next_c = w_r;
        default: hi_next_c = hi_q;
      endcase
    end
    if (w_w_lo) begin
      case (w_losource)
        2'd0:    lo_next_c = w_a;
        2'd1:    lo_next_c = w_muler_lo;
        2'd2:    lo_next_c = w_q;
        default: lo_next_c = lo_q;
      endcase
    end
  end

  // HI/LO commit only blocked by stall so a flush never drops the WB instruction's write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!wb.stall) begin
      hi_q <= hi_next_c;
      lo_q <= lo_next_c;
    end
  end

  assign wb.wb_we   = w_w_rf & (w_rn != RW'(0));
  assign wb.wb_rn   = w_rn;
  assign wb.wb_data = wb_data_c;
  assign wb.hi      = hi_q;
  assign wb.lo      = lo_q;
  assign wb.hi_next = hi_next_c;
  assign wb.lo_next = lo_next_c;
endmodule

// File: tb/tb_pipe_wb_stage.sv
// Self-checking bench for pipe_wb_stage: behavioural model with per-cycle compare plus directed literals.
module tb_pipe_wb_stage;
  typedef struct packed {
    logic [31:0] alu, a, dm, pc4, cp0, counter, q, r, mhi, mlo;
    logic [2:0]  rfs;
    logic [1:0]  cs;
    logic        sign;
    logic [1:0]  hs, ls;
    logic [4:0]  rn;
    logic        wrf, whi, wlo;
  } bundle_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    stall = 1'b0;
  logic    flush = 1'b0;
  bundle_t cur = '0;
  int      checks = 0;
  int      failures = 0;

  bundle_t     m_w;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  pipe_wb_if bus ();
  pipe_wb_stage dut (.clk(clk), .rst_n(rst_n), .wb(bus));

  assign bus.stall = stall;            assign bus.flush = flush;
  assign bus.Malu = cur.alu;           assign bus.Ma = cur.a;
  assign bus.Mdm = cur.dm;             assign bus.Mpc4 = cur.pc4;
  assign bus.Mcp0 = cur.cp0;           assign bus.Mcounter = cur.counter;
  assign bus.Mq = cur.q;               assign bus.Mr = cur.r;
  assign bus.Mmuler_hi = cur.mhi;      assign bus.Mmuler_lo = cur.mlo;
  assign bus.Mrfsource = cur.rfs;      assign bus.Mcuttersource = cur.cs;
  assign bus.Msign = cur.sign;         assign bus.Mhisource = cur.hs;
  assign bus.Mlosource = cur.ls;       assign bus.Mrn = cur.rn;
  assign bus.Mw_rf = cur.wrf;          assign bus.Mw_hi = cur.whi;
  assign bus.Mw_lo = cur.wlo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Loaded value: shift the addressed field down, mask to its width, extend
  function automatic logic [31:0] f_cut(input bundle_t b);
    logic [31:0] f;
    int w;
    f = b.dm;
    w = 32;
    if (b.cs == 2'd1) begin
      f = (b.dm >> (8 * int'(b.alu[1:0]))) & 32'h0000_00FF;
      w = 8;
    end else if (b.cs == 2'd2) begin
      f = (b.dm >> (b.alu[1] ? 16 : 0)) & 32'h0000_FFFF;
      w = 16;
    end
    if (b.sign && w < 32 && f[w-1]) f = f | (32'hFFFF_FFFF << w);
    return f;
  endfunction

  function automatic logic [31:0] f_data(input bundle_t b, input logic [31:0] h, input logic [31:0] l);
    logic [31:0] src [8];
    src[0] = b.alu; src[1] = f_cut(b); src[2] = b.pc4; src[3] = h;
    src[4] = l;     src[5] = b.cp0;    src[6] = b.counter; src[7] = b.mlo;
    return src[b.rfs];
  endfunction

  function automatic logic [31:0] f_hnext(input bundle_t b, input logic [31:0] h);
    logic [31:0] src [4];
    src[0] = b.a; src[1] = b.mhi; src[2] = b.r; src[3] = h;
    return b.whi ? src[b.hs] : h;
  endfunction

  function automatic logic [31:0] f_lnext(input bundle_t b, input logic [31:0] l);
    logic [31:0] src [4];
    src[0] = b.a; src[1] = b.mlo; src[2] = b.q; src[3] = l;
    return b.wlo ? src[b.ls] : l;
  endfunction

  // Reference model of the stage's architectural state
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_w <= '0; m_hi <= '0; m_lo <= '0;
    end else begin
      if (!stall) begin
        m_hi <= f_hnext(m_w, m_hi);
        m_lo <= f_lnext(m_w, m_lo);
      end
      if (flush) m_w <= '0;
      else if (!stall) m_w <= cur;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_wb_we", 32'(bus.wb_we), 32'(m_w.wrf && m_w.rn != 5'd0));
    chk("cyc_wb_rn", 32'(bus.wb_rn), 32'(m_w.rn));
    chk("cyc_wb_data", bus.wb_data, f_data(m_w, m_hi, m_lo));
    chk("cyc_hi", bus.hi, m_hi);
    chk("cyc_lo", bus.lo, m_lo);
    chk("cyc_hi_next", bus.hi_next, f_hnext(m_w, m_hi));
    chk("cyc_lo_next", bus.lo_next, f_lnext(m_w, m_lo));
  end

  task automatic step(input bundle_t b, input logic st, input logic fl);
    cur = b; stall = st; flush = fl;
    @(negedge clk);
  endtask

  function automatic bundle_t rnd_bundle();
    bundle_t b;
    b.alu = $urandom; b.a = $urandom; b.dm = $urandom; b.pc4 = $urandom;
    b.cp0 = $urandom; b.counter = $urandom; b.q = $urandom; b.r = $urandom;
    b.mhi = $urandom; b.mlo = $urandom;
    b.rfs = 3'($urandom_range(0, 7)); b.cs = 2'($urandom_range(0, 3));
    b.sign = 1'($urandom_range(0, 1));
    b.hs = 2'($urandom_range(0, 3)); b.ls = 2'($urandom_range(0, 3));
    b.rn = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    b.wrf = 1'($urandom_range(0, 1)); b.whi = 1'($urandom_range(0, 1));
    b.wlo = 1'($urandom_range(0, 1));
    return b;
  endfunction

  bundle_t b;
  bundle_t nop;
  logic [31:0] sweep_exp;

  initial begin
    nop = '0;
    @(negedge clk);
    chk("reset_wb_we", 32'(bus.wb_we), 32'd0);
    chk("reset_hi_next", bus.hi_next, 32'd0);
    rst_n = 1'b1;

    // Loads
    b = '0; b.dm = 32'h8081_F2F3; b.alu = 32'h1; b.cs = 2'd1; b.sign = 1'b1;
    b.rfs = 3'd1; b.rn = 5'd5; b.wrf = 1'b1;
    step(b, 1'b0, 1'b0);
    chk("lb_data", bus.wb_data, 32'hFFFF_FFF2);
    chk("lb_we", 32'(bus.wb_we), 32'd1);
    chk("lb_rn", 32'(bus.wb_rn), 32'd5);
    b.sign = 1'b0;
    step(b, 1'b0, 1'b0);
    chk("lbu_data", bus.wb_data, 32'h0000_00F2);
    b.cs = 2'd2; b.alu = 32'h2; b.sign = 1'b1;
    step(b, 1'b0, 1'b0);
    chk("lh_data", bus.wb_data, 32'hFFFF_8081);

    // Writes to $zero are suppressed
    b = '0; b.alu = 32'h1234; b.wrf = 1'b1;
    step(b, 1'b0, 1'b0);
    chk("zero_we", 32'(bus.wb_we), 32'd0);

    // HI/LO write followed by mfhi
    b = '0; b.whi = 1'b1; b.wlo = 1'b1; b.hs = 2'd2; b.ls = 2'd2; b.r = 32'd7; b.q = 32'd3;
    step(b, 1'b0, 1'b0);
    chk("hilo_hi_next", bus.hi_next, 32'd7);
    chk("hilo_lo_next", bus.lo_next, 32'd3);
    b = '0; b.rfs = 3'd3; b.rn = 5'd2; b.wrf = 1'b1;
    step(b, 1'b0, 1'b0);
    chk("hilo_hi", bus.hi, 32'd7);
    chk("hilo_lo", bus.lo, 32'd3);
    chk("mfhi_data", bus.wb_data, 32'd7);

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("areset_we", 32'(bus.wb_we), 32'd0);
    chk("areset_data", bus.wb_data, 32'd0);
    chk("areset_hi", bus.hi, 32'd0);
    chk("areset_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stall holds HI write until release
    b = '0; b.whi = 1'b1; b.hs = 2'd0; b.a = 32'hAA;
    step(b, 1'b0, 1'b0);
    chk("stall_hi_next", bus.hi_next, 32'hAA);
    chk("stall_hi_pre", bus.hi, 32'd0);
    b.a = 32'h55;
    for (int i = 0; i < 3; i++) begin
      step(b, 1'b1, 1'b0);
      chk("stall_hi_held", bus.hi, 32'd0);
    end
    step(nop, 1'b0, 1'b0);
    chk("stall_hi_release", bus.hi, 32'hAA);
    step(nop, 1'b0, 1'b0);
    chk("stall_hi_once", bus.hi, 32'hAA);

    // Flush wins over stall
    b = '0; b.wrf = 1'b1; b.rn = 5'd5; b.alu = 32'h99;
    step(b, 1'b0, 1'b0);
    chk("flush_pre_we", 32'(bus.wb_we), 32'd1);
    step(b, 1'b1, 1'b1);
    chk("flush_we", 32'(bus.wb_we), 32'd0);
    chk("flush_rn", 32'(bus.wb_rn), 32'd0);

    // Write-data select sweep
    for (int s = 0; s < 8; s++) begin
      b = '0;
      b.alu = 32'h1111_1110; b.dm = 32'h8081_F2F3; b.pc4 = 32'h2222_2222;
      b.cp0 = 32'h5555_5555; b.counter = 32'h6666_6666; b.mlo = 32'h7777_7777;
      b.rfs = 3'(s); b.rn = 5'(s + 1); b.wrf = 1'b1;
      step(b, 1'b0, 1'b0);
      case (s)
        0: sweep_exp = 32'h1111_1110;
        1: sweep_exp = 32'h8081_F2F3;
        2: sweep_exp = 32'h2222_2222;
        3: sweep_exp = 32'hAA;
        4: sweep_exp = 32'h0;
        5: sweep_exp = 32'h5555_5555;
        6: sweep_exp = 32'h6666_6666;
        default: sweep_exp = 32'h7777_7777;
      endcase
      chk("sweep_data", bus.wb_data, sweep_exp);
    end

    // Randomized traffic checked by the per-cycle compare
    for (int n = 0; n < 400; n++) begin
      step(rnd_bundle(), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 99) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
